// File: rtl/trax_pkg.sv
// Shared Trax definitions: cell and tile encodings, board bounds,
// and the state set of the board neighbour fetch FSM.
package trax_pkg;

  // Cell code stored in the board RAM; zero means no tile placed.
  localparam logic [2:0] EMPTY = 3'b000;

  // Tile shapes.
  localparam logic [1:0] TILE_PLUS   = 2'b01;
  localparam logic [1:0] TILE_SLASH  = 2'b10;
  localparam logic [1:0] TILE_BSLASH = 2'b11;

  // Track colours.
  localparam logic COLOUR_WHITE = 1'b0;
  localparam logic COLOUR_RED   = 1'b1;

  // Board bounds and move list depth.
  localparam int MAX_ROW         = 50;
  localparam int MAX_COL         = 50;
  localparam int MAX_VALID_MOVES = 203;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RC,
    S_RU,
    S_RD,
    S_RL,
    S_RR,
    S_CAP,
    S_EMIT,
    S_NEXT,
    S_DONE
  } fetch_state_t;

  // Clamp a requested board dimension to the hardware bound.
  function automatic logic [9:0] clamp_dim(
    input logic [9:0] v,
    input logic [9:0] lim
  );
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/board_cursor.sv
// Row-major (row, col) walker over an m_eff x n_eff board.
// Ports: i_load latches dims and zeroes the cursor; i_adv steps it;
// o_row/o_col position; edge flags for neighbour range; o_last on
// the final cell (cursor does not move past it).
module board_cursor (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_adv,
  input  logic [9:0] i_m_eff,
  input  logic [9:0] i_n_eff,
  output logic [9:0] o_row,
  output logic [9:0] o_col,
  output logic       o_row_first,
  output logic       o_row_last,
  output logic       o_col_first,
  output logic       o_col_last,
  output logic       o_last
);

  logic [9:0] r_row;
  logic [9:0] r_col;
  logic [9:0] r_m_eff;
  logic [9:0] r_n_eff;

  assign o_row       = r_row;
  assign o_col       = r_col;
  assign o_row_first = (r_row == 10'd0);
  assign o_col_first = (r_col == 10'd0);
  assign o_row_last  = (r_row == r_n_eff - 10'd1);
  assign o_col_last  = (r_col == r_m_eff - 10'd1);
  assign o_last      = o_row_last && o_col_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row   <= '0;
      r_col   <= '0;
      r_m_eff <= '0;
      r_n_eff <= '0;
    end else if (i_load) begin
      r_row   <= '0;
      r_col   <= '0;
      r_m_eff <= i_m_eff;
      r_n_eff <= i_n_eff;
    end else if (i_adv && !o_last) begin
      if (o_col_last) begin
        r_col <= '0;
        r_row <= r_row + 10'd1;
      end else begin
        r_col <= r_col + 10'd1;
      end
    end
  end

endmodule

// File: rtl/board_neighbour_fetch.sv
// Scans the board row-major, reading each cell and its in-range
// neighbours, and presents empty cells that touch a placed tile.
// Ports: clk/rst; start,m,n scan request; rd_* board RAM read port
// (data one cycle after rd_en); cell_valid/cell_ready handshake with
// r,c and up/right/down/left codes; busy, done pulse, emit_count.
module board_neighbour_fetch #(
  parameter int MAX_ROW = 50,
  parameter int MAX_COL = 50,
  parameter int CNT_W   = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [9:0]       m,
  input  logic [9:0]       n,
  output logic             rd_en,
  output logic [9:0]       rd_row,
  output logic [9:0]       rd_col,
  input  logic [2:0]       rd_data,
  output logic             cell_valid,
  input  logic             cell_ready,
  output logic [9:0]       r,
  output logic [9:0]       c,
  output logic [2:0]       up_cell,
  output logic [2:0]       right_cell,
  output logic [2:0]       down_cell,
  output logic [2:0]       left_cell,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] emit_count
);

  import trax_pkg::*;

  fetch_state_t     r_state;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic [2:0]       r_up;
  logic [2:0]       r_right;
  logic [2:0]       r_down;
  logic [2:0]       r_left;
  logic [CNT_W-1:0] r_cnt;
  logic [9:0]       r_row_q;
  logic [9:0]       r_col_q;

  logic [9:0] w_m_eff;
  logic [9:0] w_n_eff;
  logic       w_load;
  logic       w_adv;
  logic [9:0] w_r;
  logic [9:0] w_c;
  logic       w_row_first;
  logic       w_row_last;
  logic       w_col_first;
  logic       w_col_last;
  logic       w_last;
  logic       w_centre_empty;
  logic [2:0] w_right;
  logic       w_rd_en;
  logic [9:0] w_row;
  logic [9:0] w_col;

  assign w_m_eff = clamp_dim(m, 10'(MAX_COL));
  assign w_n_eff = clamp_dim(n, 10'(MAX_ROW));
  assign w_load  = (r_state == S_IDLE) && start;
  assign w_adv   = (r_state == S_NEXT);

  board_cursor u_cursor (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_adv       (w_adv),
    .i_m_eff     (w_m_eff),
    .i_n_eff     (w_n_eff),
    .o_row       (w_r),
    .o_col       (w_c),
    .o_row_first (w_row_first),
    .o_row_last  (w_row_last),
    .o_col_first (w_col_first),
    .o_col_last  (w_col_last),
    .o_last      (w_last)
  );

  assign w_centre_empty = (rd_data == EMPTY);
  assign w_right        = w_col_last ? EMPTY : rd_data;

  // The read strobe in RU depends on the centre code arriving that
  // same cycle, so the read port is decoded from state rather than
  // registered; an occupied centre then costs no extra reads.
  always_comb begin
    w_rd_en = 1'b0;
    w_row   = w_r;
    w_col   = w_c;
    unique case (r_state)
      S_RC: w_rd_en = 1'b1;
      S_RU: begin
        w_rd_en = w_centre_empty && !w_row_first;
        w_row   = w_r - 10'd1;
      end
      S_RD: begin
        w_rd_en = !w_row_last;
        w_row   = w_r + 10'd1;
      end
      S_RL: begin
        w_rd_en = !w_col_first;
        w_col   = w_c - 10'd1;
      end
      S_RR: begin
        w_rd_en = !w_col_last;
        w_col   = w_c + 10'd1;
      end
      default: ;
    endcase
  end

  assign rd_en  = w_rd_en;
  assign rd_row = w_rd_en ? w_row : r_row_q;
  assign rd_col = w_rd_en ? w_col : r_col_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_q <= '0;
      r_col_q <= '0;
    end else begin
      r_row_q <= rd_row;
      r_col_q <= rd_col;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_up    <= EMPTY;
      r_right <= EMPTY;
      r_down  <= EMPTY;
      r_left  <= EMPTY;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (w_m_eff == 10'd0 || w_n_eff == 10'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RC;
            end
          end
        end
        S_RC: r_state <= S_RU;
        S_RU: r_state <= w_centre_empty ? S_RD : S_NEXT;
        S_RD: begin
          r_up    <= w_row_first ? EMPTY : rd_data;
          r_state <= S_RL;
        end
        S_RL: begin
          r_down  <= w_row_last ? EMPTY : rd_data;
          r_state <= S_RR;
        end
        S_RR: begin
          r_left  <= w_col_first ? EMPTY : rd_data;
          r_state <= S_CAP;
        end
        S_CAP: begin
          r_right <= w_right;
          if ((r_up | r_down | r_left | w_right) == EMPTY) begin
            r_state <= S_NEXT;
          end else begin
            r_state <= S_EMIT;
            r_valid <= 1'b1;
          end
        end
        S_EMIT: begin
          if (r_valid && cell_ready) begin
            r_valid <= 1'b0;
            r_state <= S_NEXT;
            if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          end
        end
        S_NEXT: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_RC;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cell_valid = r_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign r          = w_r;
  assign c          = w_c;
  assign up_cell    = r_up;
  assign right_cell = r_right;
  assign down_cell  = r_down;
  assign left_cell  = r_left;
  assign emit_count = r_cnt;

endmodule

// File: tb/tb_board_neighbour_fetch.sv
// Directed and randomized scans of board_neighbour_fetch checked
// against a cell-by-cell reference model of the scan rules.
module tb_board_neighbour_fetch;

  localparam int CNT_W = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [9:0]       m = '0;
  logic [9:0]       n = '0;
  logic             rd_en;
  logic [9:0]       rd_row;
  logic [9:0]       rd_col;
  logic [2:0]       rd_data = '0;
  logic             cell_valid;
  logic             cell_ready = 1'b0;
  logic [9:0]       r;
  logic [9:0]       c;
  logic [2:0]       up_cell;
  logic [2:0]       right_cell;
  logic [2:0]       down_cell;
  logic [2:0]       left_cell;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] emit_count;

  always #5 clk = ~clk;

  board_neighbour_fetch #(
    .MAX_ROW (50),
    .MAX_COL (50),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .m          (m),
    .n          (n),
    .rd_en      (rd_en),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_data    (rd_data),
    .cell_valid (cell_valid),
    .cell_ready (cell_ready),
    .r          (r),
    .c          (c),
    .up_cell    (up_cell),
    .right_cell (right_cell),
    .down_cell  (down_cell),
    .left_cell  (left_cell),
    .busy       (busy),
    .done       (done),
    .emit_count (emit_count)
  );

  logic [2:0] board [64][64];

  int tests = 0;
  int fails = 0;

  function automatic logic [2:0] mem_rd(input logic [9:0] rr,
                                        input logic [9:0] cc);
    if (rr < 10'd64 && cc < 10'd64) return board[rr][cc];
    return 3'b000;
  endfunction

  // RAM model; garbage when not read so forced zeros are exercised.
  always @(posedge clk)
    rd_data <= rd_en ? mem_rd(rd_row, rd_col)
                     : 3'($urandom_range(1, 7));

  logic [31:0] w_b;
  assign w_b = {r, c, up_cell, right_cell, down_cell, left_cell};

  bit          mon_en = 1'b0;
  int          cur_m = 0;
  int          cur_n = 0;
  int          rd_cnt, bad_rd, done_cnt, busy_cyc, stall, unstable, vis;
  bit          prev_hold;
  logic [31:0] prev_b;
  logic [31:0] got_q [$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_en) begin
        rd_cnt++;
        if (int'(rd_row) >= cur_n || int'(rd_col) >= cur_m) bad_rd++;
      end
      if (done) done_cnt++;
      if (busy && !done) busy_cyc++;
      if (cell_valid) vis++;
      if (cell_valid && !cell_ready) stall++;
      if (prev_hold && (!cell_valid || w_b !== prev_b)) unstable++;
      if (cell_valid && cell_ready) got_q.push_back(w_b);
      prev_hold = cell_valid && !cell_ready;
      prev_b    = w_b;
    end
  end

  logic [31:0] exp_q [$];
  int          exp_reads;
  int          exp_cyc;

  function automatic logic [2:0] cell_at(int rr, int cc, int me, int ne);
    if (rr < 0 || cc < 0 || rr >= ne || cc >= me) return 3'b000;
    return board[rr][cc];
  endfunction

  // Expected emits, reads and busy cycles straight from the scan rules.
  task automatic build_model(input int me, input int ne);
    logic [2:0] u, rt, d, l;
    exp_q.delete();
    exp_reads = 0;
    exp_cyc   = 0;
    for (int rr = 0; rr < ne; rr++) begin
      for (int cc = 0; cc < me; cc++) begin
        exp_reads++;
        if (board[rr][cc] != 3'b000) begin
          exp_cyc += 3;
        end else begin
          u  = cell_at(rr - 1, cc, me, ne);
          d  = cell_at(rr + 1, cc, me, ne);
          l  = cell_at(rr, cc - 1, me, ne);
          rt = cell_at(rr, cc + 1, me, ne);
          exp_reads += int'(rr > 0) + int'(rr < ne - 1)
                     + int'(cc > 0) + int'(cc < me - 1);
          if ({u, rt, d, l} == 12'd0) begin
            exp_cyc += 7;
          end else begin
            exp_cyc += 8;
            exp_q.push_back({10'(rr), 10'(cc), u, rt, d, l});
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_board();
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++)
        board[i][j] = 3'b000;
  endtask

  task automatic fill_random(input int pct);
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++)
        board[i][j] = ($urandom_range(0, 99) < pct)
                    ? 3'($urandom_range(1, 7)) : 3'b000;
  endtask

  // mode 0: ready high; 1: random ready; 2: first emit held 5 cycles.
  task automatic run_scan(input string name, input int mi, input int ni,
                          input int mode);
    int me, ne, cyc;
    me = (mi > 50) ? 50 : mi;
    ne = (ni > 50) ? 50 : ni;
    cur_m = me;
    cur_n = ne;
    build_model(me, ne);
    got_q.delete();
    rd_cnt = 0; bad_rd = 0; done_cnt = 0; busy_cyc = 0;
    stall = 0; unstable = 0; vis = 0; prev_hold = 1'b0;
    @(posedge clk); #1;
    m = 10'(mi);
    n = 10'(ni);
    start = 1'b1;
    cell_ready = (mode == 0);
    mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 20000) begin
      if (mode == 1) cell_ready = 1'($urandom_range(0, 1));
      if (mode == 2) cell_ready = (vis >= 5);
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " no_timeout"}, 64'(cyc < 20000), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    mon_en = 1'b0;
    cell_ready = 1'b0;
    check({name, " done_pulses"}, 64'(done_cnt), 64'd1);
    check({name, " emits"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s emit[%0d]", name, i), 64'(got_q[i]),
            64'(exp_q[i]));
    check({name, " emit_count"}, 64'(emit_count), 64'(exp_q.size()));
    check({name, " reads"}, 64'(rd_cnt), 64'(exp_reads));
    check({name, " oob_reads"}, 64'(bad_rd), 64'd0);
    check({name, " hold_stable"}, 64'(unstable), 64'd0);
    check({name, " busy_cycles"}, 64'(busy_cyc), 64'(exp_cyc + stall));
    check({name, " idle_busy"}, 64'(busy), 64'd0);
    if (mode == 2) check({name, " stalls"}, 64'(stall), 64'd5);
  endtask

  initial begin
    int wt, dcnt;
    #1 rst = 1'b1;
    #12;
    check("rst rd_en", 64'(rd_en), 64'd0);
    check("rst valid", 64'(cell_valid), 64'd0);
    check("rst busy_done", 64'({busy, done}), 64'd0);
    check("rst rc", 64'({r, c}), 64'd0);
    check("rst nbrs", 64'({up_cell, right_cell, down_cell, left_cell}),
          64'd0);
    check("rst count", 64'(emit_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of the down-read of cell (0,0).
    clear_board();
    board[1][1] = 3'b001;
    @(posedge clk); #1;
    m = 10'd3; n = 10'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wt = 0;
    while (!rd_en && wt < 20) begin
      @(negedge clk);
      wt++;
    end
    check("midrst rc_seen", 64'(rd_en), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("midrst pre busy_rd", 64'({busy, rd_en}), 64'b11);
    rst = 1'b1;
    #1;
    check("midrst valid", 64'(cell_valid), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst rd_en", 64'(rd_en), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("midrst no_done", 64'(dcnt), 64'd0);

    clear_board();
    board[1][1] = 3'b001;
    run_scan("center3x3", 3, 3, 0);
    run_scan("backpress", 3, 3, 2);

    clear_board();
    run_scan("single", 1, 1, 0);
    run_scan("m_zero", 0, 5, 0);

    clear_board();
    board[0][0] = 3'b001;
    run_scan("corner2x2", 2, 2, 0);

    for (int k = 0; k < 8; k++) begin
      fill_random(30);
      run_scan($sformatf("rand%0d", k), $urandom_range(1, 9),
               $urandom_range(1, 9), 1);
    end

    fill_random(25);
    run_scan("clamp_cols", 57, 2, 0);
    fill_random(25);
    run_scan("clamp_rows", 1, 53, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
